// File: rtl/pipeline_control_unit_pkg.sv
// Shared types and default sizing for the in-order pipeline controller.
// Optional perf counter in the top is enabled by PIPELINE_CTRL_PERF_EN.
package PipelineControlTypes;

    typedef enum logic [1:0] {
        DRAIN_IDLE,
        DRAIN_ACTIVE,
        DRAIN_DONE
    } DrainPhase;

    localparam int DEFAULT_NUM_STAGES    = 10;
    localparam int DEFAULT_DRAIN_TIMEOUT = 255;
    localparam int DEFAULT_CNT_WIDTH     = 8;

endpackage

// File: rtl/pipeline_control_unit_drain_fsm.sv
// Drain sequencer: empties the pipeline on request, with a sticky timeout.
// Grant and timeout read as 0 while rst is held.
import PipelineControlTypes::*;

module pipeline_drain_fsm #(
    parameter int DRAIN_TIMEOUT = DEFAULT_DRAIN_TIMEOUT,
    parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic drainReq,
    input  logic pipeEmpty,
    output logic injectStall0,
    output logic injectClear0,
    output logic drainGrant,
    output logic drainTimeout
);

    localparam logic [CNT_WIDTH-1:0] TO_CNT = CNT_WIDTH'(DRAIN_TIMEOUT);

    DrainPhase             state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            DRAIN_IDLE: begin
                if (drainReq) begin
                    state_d = DRAIN_ACTIVE;
                    cnt_d   = '0;
                end
            end
            DRAIN_ACTIVE: begin
                if (!drainReq) begin
                    state_d   = DRAIN_IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end else begin
                    if (cnt_q != TO_CNT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (pipeEmpty) begin
                        state_d = DRAIN_DONE;
                    end else if (cnt_q == TO_CNT) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            DRAIN_DONE: begin
                if (!drainReq) begin
                    state_d = DRAIN_IDLE;
                end
            end
            default: state_d = DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DRAIN_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign injectStall0 = (state_q != DRAIN_IDLE);
    assign injectClear0 = (state_q != DRAIN_IDLE);
    assign drainGrant   = (state_q == DRAIN_DONE) && !rst;
    assign drainTimeout = timeout_q && !rst;

endmodule

// File: rtl/pipeline_control_unit.sv
// Per-stage stall/clear resolution for NUM_STAGES in-order stages plus drain.
// Define PIPELINE_CTRL_PERF_EN to add the stallCycleCount port.
import PipelineControlTypes::*;

module pipeline_control_unit #(
    parameter int NUM_STAGES    = DEFAULT_NUM_STAGES,
    parameter int DRAIN_TIMEOUT = DEFAULT_DRAIN_TIMEOUT,
    parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stallUpperReq,
    input  logic [NUM_STAGES-1:0] flushUpperReq,
    input  logic [NUM_STAGES-1:0] bubbleLowerReq,
    input  logic [NUM_STAGES-1:0] stageEmpty,
    input  logic                  backendEmpty,
    input  logic                  drainReq,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] clear,
    output logic                  wholePipelineEmpty,
    output logic                  drainGrant,
    output logic                  drainTimeout
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0]           stallCycleCount
`endif
);

    logic injectStall0;
    logic injectClear0;
    logic stall_acc;
    logic flush_acc;

    assign wholePipelineEmpty = (&stageEmpty) & backendEmpty;

    pipeline_drain_fsm #(
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_drain (
        .clk          (clk),
        .rst          (rst),
        .drainReq     (drainReq),
        .pipeEmpty    (wholePipelineEmpty),
        .injectStall0 (injectStall0),
        .injectClear0 (injectClear0),
        .drainGrant   (drainGrant),
        .drainTimeout (drainTimeout)
    );

    // Walk downstream-to-upstream so stall and flush accumulate as prefix ORs.
    always_comb begin
        stall     = '0;
        clear     = '0;
        stall_acc = 1'b0;
        flush_acc = 1'b0;
        for (int j = NUM_STAGES - 1; j >= 0; j--) begin
            stall_acc = stall_acc | stallUpperReq[j];
            stall[j]  = stall_acc & ~flush_acc;
            clear[j]  = stallUpperReq[j] | bubbleLowerReq[j] | flush_acc;
            if (j == 0) begin
                stall[j] = (stall_acc | injectStall0) & ~flush_acc;
                clear[j] = clear[j] | injectClear0;
            end
            flush_acc = flush_acc | flushUpperReq[j];
        end
        if (rst) begin
            stall = '0;
            clear = '1;
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall[0] && !injectStall0) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallCycleCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Self-checking bench for pipeline_control_unit (NUM_STAGES=10, DRAIN_TIMEOUT=5).
// Directed test-plan vectors followed by randomized traffic against a model.
module tb_pipeline_control_unit;

    localparam int N  = 10;
    localparam int TO = 5;
    localparam int CW = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] stallReq, flushReq, bubbleReq, stageEmpty;
    logic         backendEmpty, drainReq;
    logic [N-1:0] stall, clear;
    logic         wpe, drainGrant, drainTimeout;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0]  stallCycleCount;
`endif

    pipeline_control_unit #(
        .NUM_STAGES    (N),
        .DRAIN_TIMEOUT (TO),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .stallUpperReq      (stallReq),
        .flushUpperReq      (flushReq),
        .bubbleLowerReq     (bubbleReq),
        .stageEmpty         (stageEmpty),
        .backendEmpty       (backendEmpty),
        .drainReq           (drainReq),
        .stall              (stall),
        .clear              (clear),
        .wholePipelineEmpty (wpe),
        .drainGrant         (drainGrant),
        .drainTimeout       (drainTimeout)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .stallCycleCount    (stallCycleCount)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: draining / drained flags, cycles spent draining.
    bit          m_draining, m_drained, m_to;
    int          m_cycles;
    int unsigned m_perf;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_stall();
        logic [N-1:0] r;
        for (int j = 0; j < N; j++) begin
            logic f, s;
            f = ((flushReq >> (j + 1)) != 0);
            s = ((stallReq >> j) != 0) ||
                (j == 0 && (m_draining || m_drained));
            r[j] = !rst && s && !f;
        end
        return r;
    endfunction

    function automatic logic [N-1:0] exp_clear();
        logic [N-1:0] r;
        for (int j = 0; j < N; j++) begin
            logic f;
            f = ((flushReq >> (j + 1)) != 0);
            r[j] = rst || stallReq[j] || bubbleReq[j] || f ||
                   (j == 0 && (m_draining || m_drained));
        end
        return r;
    endfunction

    task automatic check_outputs();
        logic [N-1:0] es;
        es = exp_stall();
        chk("stall", 32'(stall), 32'(es));
        chk("clear", 32'(clear), 32'(exp_clear()));
        chk("empty", 32'(wpe), 32'((&stageEmpty) && backendEmpty));
        chk("grant", 32'(drainGrant), 32'(!rst && m_drained));
        chk("timeout", 32'(drainTimeout), 32'(!rst && m_to));
`ifdef PIPELINE_CTRL_PERF_EN
        chk("perf", stallCycleCount, m_perf);
`endif
    endtask

    task automatic model_update();
        logic [N-1:0] es;
        logic         empty;
        es    = exp_stall();
        empty = (&stageEmpty) && backendEmpty;
        if (rst) begin
            m_draining = 0;
            m_drained  = 0;
            m_to       = 0;
            m_cycles   = 0;
            m_perf     = 0;
        end else begin
            if (es[0] && !m_draining && !m_drained) m_perf++;
            if (m_draining) begin
                if (!drainReq) begin
                    m_draining = 0;
                    m_to       = 0;
                    m_cycles   = 0;
                end else begin
                    if (empty) begin
                        m_draining = 0;
                        m_drained  = 1;
                    end else if (m_cycles >= TO) begin
                        m_to = 1;
                    end
                    m_cycles = (m_cycles + 1 > TO) ? TO : m_cycles + 1;
                end
            end else if (m_drained) begin
                if (!drainReq) m_drained = 0;
            end else if (drainReq) begin
                m_draining = 1;
                m_cycles   = 0;
            end
        end
    endtask

    task automatic tick();
        #1 check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stallReq     = '0;
        flushReq     = '0;
        bubbleReq    = '0;
        stageEmpty   = '1;
        backendEmpty = 1'b1;
        drainReq     = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
        chk("rst_clear", 32'(clear), 32'(10'h3ff));
        chk("rst_stall", 32'(stall), 0);
        tick();
        rst = 1'b0;
        tick();

        stallReq = 10'b0000001000;
        #1;
        chk("tp1_stall", 32'(stall), 32'(10'b0000001111));
        chk("tp1_clear", 32'(clear), 32'(10'b0000001000));
        tick();
        flushReq = 10'b0001000000;
        #1;
        chk("tp2_stall", 32'(stall), 0);
        chk("tp2_clear", 32'(clear), 32'(10'b0000111111));
        tick();
        stallReq  = '0;
        flushReq  = 10'b0000000100;
        bubbleReq = 10'b0100000000;
        #1;
        chk("tp3_clear", 32'(clear), 32'(10'b0100000011));
        chk("tp3_stall", 32'(stall), 0);
        tick();

        idle_inputs();
        drainReq = 1'b1;
        tick();
        #1;
        chk("tp4_draining_grant", 32'(drainGrant), 0);
        chk("tp4_draining_stall0", 32'(stall[0]), 1);
        tick();
        #1 chk("tp4_grant", 32'(drainGrant), 1);
        tick();
        tick();
        drainReq = 1'b0;
        #1 chk("tp4_grant_hold", 32'(drainGrant), 1);
        tick();
        #1;
        chk("tp4_grant_drop", 32'(drainGrant), 0);
        chk("tp4_stall0", 32'(stall[0]), 0);
        tick();

        stageEmpty[4] = 1'b0;
        drainReq      = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        #1;
        chk("tp5_timeout", 32'(drainTimeout), 1);
        chk("tp5_nogrant", 32'(drainGrant), 0);
        stageEmpty[4] = 1'b1;
        tick();
        #1 chk("tp5_grant", 32'(drainGrant), 1);
        tick();

        rst = 1'b1;
        #1;
        chk("tp6_rst_grant", 32'(drainGrant), 0);
        chk("tp6_rst_clear", 32'(clear), 32'(10'h3ff));
        tick();
        rst      = 1'b0;
        drainReq = 1'b0;
        #1;
        chk("tp6_idle_grant", 32'(drainGrant), 0);
        chk("tp6_idle_stall0", 32'(stall[0]), 0);
        tick();

        for (int c = 0; c < 3000; c++) begin
            stallReq     = N'($urandom & $urandom & $urandom);
            flushReq     = N'($urandom & $urandom & $urandom & $urandom);
            bubbleReq    = N'($urandom & $urandom);
            stageEmpty   = ~N'($urandom & $urandom & $urandom & $urandom);
            backendEmpty = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) drainReq = ~drainReq;
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
